// File: rtl/alu_mdu_if.sv
// alu_mdu_if: execute-stage bus between the pipeline and the alu_mdu block.
// Carries the ALU operands/result and the multiply/divide request, busy
// flag and HI/LO readback. clk and reset stay plain module ports.
interface alu_mdu_if #(
    parameter int WIDTH = 32
);
    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [SHW-1:0]   shamt;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_out;
    logic [2:0]       md_op;
    logic             md_start;
    logic             md_busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Pipeline side: drives operands and requests, observes results.
    modport master (
        output src_a, src_b, shamt, alu_op, md_op, md_start,
        input  alu_out, md_busy, hi, lo
    );

    // Arithmetic block side.
    modport slave (
        input  src_a, src_b, shamt, alu_op, md_op, md_start,
        output alu_out, md_busy, hi, lo
    );
endinterface

// File: rtl/alu_mdu.sv
// alu_mdu: execute-stage arithmetic block.
//  - Combinational ALU (add/sub/or/and/lui/slt/sltu/sll/srl/sra).
//  - Sequential multiply/divide unit owning the HI/LO registers.
//    Multiply completes MUL_CYCLES edges after the start edge; divide is a
//    restoring divider producing one quotient bit per cycle (WIDTH cycles).
// Configuration macro: MDU_DIV_EN. When undefined there is no divider and
// div/divu requests behave like md_op none.
module alu_mdu #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5
) (
    input  logic     clk,
    input  logic     reset,
    alu_mdu_if.slave bus
);
    localparam int CNT_MAX = (MUL_CYCLES > WIDTH) ? MUL_CYCLES : WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_n;
    logic               busy_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               start_mul_s;
    logic               start_div_s;
    logic               done_mul_s;
    logic               done_div_s;
    logic               mthi_s;
    logic               mtlo_s;

    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               signed_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic [2*WIDTH-1:0] ext_a_s;
    logic [2*WIDTH-1:0] ext_b_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   alu_res_s;

    // ---------------------------------------------------------------
    // Combinational ALU
    // ---------------------------------------------------------------

    // ALU result selection; independent of the multiply/divide state.
    always_comb begin
        alu_res_s = '0;
        case (bus.alu_op)
            4'd0:    alu_res_s = bus.src_a + bus.src_b;
            4'd1:    alu_res_s = bus.src_a - bus.src_b;
            4'd2:    alu_res_s = bus.src_a | bus.src_b;
            4'd3:    alu_res_s = bus.src_a & bus.src_b;
            4'd4:    alu_res_s = {bus.src_b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            4'd5:    alu_res_s = ($signed(bus.src_a) < $signed(bus.src_b)) ? ONE_W : '0;
            4'd6:    alu_res_s = (bus.src_a < bus.src_b) ? ONE_W : '0;
            4'd7:    alu_res_s = bus.src_b << bus.shamt;
            4'd8:    alu_res_s = bus.src_b >> bus.shamt;
            4'd9:    alu_res_s = $signed(bus.src_b) >>> bus.shamt;
            default: alu_res_s = '0;
        endcase
    end

    assign bus.alu_out = alu_res_s;
    assign bus.md_busy = busy_r;
    assign bus.hi      = hi_r;
    assign bus.lo      = lo_r;

    // ---------------------------------------------------------------
    // Multiply/divide control FSM
    // ---------------------------------------------------------------

    // Next-state and control strobes; starts are only honoured from IDLE,
    // so a request on the completion edge is dropped.
    always_comb begin
        state_n     = state_r;
        start_mul_s = 1'b0;
        start_div_s = 1'b0;
        done_mul_s  = 1'b0;
        done_div_s  = 1'b0;
        mthi_s      = 1'b0;
        mtlo_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.md_start) begin
                    case (bus.md_op)
                        OP_MULT, OP_MULTU: begin
                            state_n     = ST_MUL;
                            start_mul_s = 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
`ifdef MDU_DIV_EN
                            state_n     = ST_DIV;
                            start_div_s = 1'b1;
`else
                            state_n     = ST_IDLE;
`endif
                        end
                        OP_MTHI: mthi_s  = 1'b1;
                        OP_MTLO: mtlo_s  = 1'b1;
                        default: state_n = ST_IDLE;
                    endcase
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (cnt_r == MUL_LAST) begin
                    state_n    = ST_IDLE;
                    done_mul_s = 1'b1;
                end else begin
                    state_n = ST_MUL;
                end
            end
            ST_DIV: begin
`ifdef MDU_DIV_EN
                if (cnt_r == CNT_W'(WIDTH - 1)) begin
                    state_n    = ST_IDLE;
                    done_div_s = 1'b1;
                end else begin
                    state_n = ST_DIV;
                end
`else
                state_n = ST_IDLE;
`endif
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State register, registered busy flag and cycle counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_n;
            busy_r  <= (state_n != ST_IDLE);
            if ((state_n == ST_IDLE) || start_mul_s || start_div_s) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // ---------------------------------------------------------------
    // Multiplier: operands are latched, product is taken at completion
    // ---------------------------------------------------------------

    assign ext_a_s = signed_r ? {{WIDTH{a_r[WIDTH-1]}}, a_r} : {{WIDTH{1'b0}}, a_r};
    assign ext_b_s = signed_r ? {{WIDTH{b_r[WIDTH-1]}}, b_r} : {{WIDTH{1'b0}}, b_r};
    assign prod_s  = ext_a_s * ext_b_s;

`ifdef MDU_DIV_EN
    // ---------------------------------------------------------------
    // Restoring divider on magnitudes with sign fix-up at completion
    // ---------------------------------------------------------------

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] d_r;
    logic             neg_q_r;
    logic             neg_r_r;
    logic             div_zero_r;
    logic             is_sdiv_s;
    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] rem_step_s;
    logic [WIDTH-1:0] q_step_s;
    logic [WIDTH-1:0] div_hi_s;
    logic [WIDTH-1:0] div_lo_s;

    function automatic logic [WIDTH-1:0] neg_f(input logic [WIDTH-1:0] x);
        return ~x + ONE_W;
    endfunction

    function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] x,
                                               input logic is_signed);
        logic [WIDTH-1:0] r;
        if (is_signed && x[WIDTH-1]) begin
            r = neg_f(x);
        end else begin
            r = x;
        end
        return r;
    endfunction

    assign is_sdiv_s = (bus.md_op == OP_DIV);

    // One restoring step plus the final sign / divide-by-zero fix-up.
    always_comb begin
        rem_sh_s = {rem_r, q_r[WIDTH-1]};
        diff_s   = rem_sh_s - {1'b0, d_r};
        if (!diff_s[WIDTH]) begin
            rem_step_s = diff_s[WIDTH-1:0];
            q_step_s   = {q_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_step_s = rem_sh_s[WIDTH-1:0];
            q_step_s   = {q_r[WIDTH-2:0], 1'b0};
        end
        if (div_zero_r) begin
            div_lo_s = '1;
            div_hi_s = a_r;
        end else begin
            div_lo_s = neg_q_r ? neg_f(q_step_s)   : q_step_s;
            div_hi_s = neg_r_r ? neg_f(rem_step_s) : rem_step_s;
        end
    end

    // Divider working registers: load magnitudes on start, iterate in DIV.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_r        <= '0;
            rem_r      <= '0;
            d_r        <= '0;
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            div_zero_r <= 1'b0;
        end else if (start_div_s) begin
            q_r        <= mag_f(bus.src_a, is_sdiv_s);
            d_r        <= mag_f(bus.src_b, is_sdiv_s);
            rem_r      <= '0;
            neg_q_r    <= is_sdiv_s & (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
            neg_r_r    <= is_sdiv_s & bus.src_a[WIDTH-1];
            div_zero_r <= (bus.src_b == '0);
        end else if (state_r == ST_DIV) begin
            q_r   <= q_step_s;
            rem_r <= rem_step_s;
        end
    end
`endif

    // Operand latch and HI/LO registers; HI/LO change only on mthi/mtlo or
    // on the completion edge of a multi-cycle operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_r      <= '0;
            b_r      <= '0;
            signed_r <= 1'b0;
            hi_r     <= '0;
            lo_r     <= '0;
        end else begin
            if (start_mul_s || start_div_s) begin
                a_r      <= bus.src_a;
                b_r      <= bus.src_b;
                signed_r <= (bus.md_op == OP_MULT) || (bus.md_op == OP_DIV);
            end
            if (mthi_s) begin
                hi_r <= bus.src_a;
            end
            if (mtlo_s) begin
                lo_r <= bus.src_a;
            end
            if (done_mul_s) begin
                hi_r <= prod_s[2*WIDTH-1:WIDTH];
                lo_r <= prod_s[WIDTH-1:0];
            end
`ifdef MDU_DIV_EN
            if (done_div_s) begin
                hi_r <= div_hi_s;
                lo_r <= div_lo_s;
            end
`endif
        end
    end
endmodule
